// File: rtl/fetch_exec_sequencer.sv
// Fetch/execute sequencer paired with the CPU timing generator.
// Fetches into ir, handshakes execute beats, and pulses done per step.
module fetch_exec_sequencer #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [DW-1:0] HALT_OP = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          T1_Mif,
  input  logic          T2_Mif,
  input  logic          T1,
  input  logic          T2,
  input  logic          T3,
  input  logic          T4,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_req,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          ex_req,
  output logic [1:0]    ex_beat,
  input  logic          ex_ack,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  input  logic          halt_req,
  output logic          done,
  output logic [1:0]    cnt_set,
  output logic          stop,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] faddr;
  logic          halt_pend;
  logic          any_t;
  logic [1:0]    beat_n;
  logic          fetch_ack;

  assign any_t     = T1 | T2 | T3 | T4;
  assign fetch_ack = (state == S_FETCH) & mem_ack;

  // Beat index of the incoming execute pulse (lowest beat wins)
  always_comb begin
    beat_n = 2'd0;
    if (T1)      beat_n = 2'd0;
    else if (T2) beat_n = 2'd1;
    else if (T3) beat_n = 2'd2;
    else if (T4) beat_n = 2'd3;
  end

  // Sequencing FSM; ir and fetch address are captured alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      faddr   <= RESET_PC;
      ex_beat <= 2'd0;
      ir      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (T1_Mif) begin
            state <= S_FETCH;
            faddr <= pc;
          end else if (any_t) begin
            state   <= S_EXEC;
            ex_beat <= beat_n;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            state <= S_DONE;
          end
        end
        S_EXEC: begin
          if (ex_ack) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Program counter: jump strobe beats the fetch increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= pc_load_val;
    end else if (fetch_ack) begin
      pc <= pc + AW'(1);
    end
  end

  // Halt latch: a new request outranks the decode-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_pend <= 1'b0;
    end else if (halt_req) begin
      halt_pend <= 1'b1;
    end else if (T2_Mif && stop) begin
      halt_pend <= 1'b0;
    end
  end

  assign mem_rd_req = (state == S_FETCH);
  assign ex_req     = (state == S_EXEC);
  assign done       = (state == S_DONE);
  assign mem_addr   = mem_rd_req ? faddr : pc;
  assign cnt_set    = ir[DW-1 -: 2];
  assign stop       = (ir == HALT_OP) | halt_pend;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed bench for fetch_exec_sequencer with a transaction-level
// reference model compared every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_fetch_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       T1_Mif, T2_Mif, T1, T2, T3, T4;
  logic [7:0] mem_addr;
  logic       mem_rd_req;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       ex_req;
  logic [1:0] ex_beat;
  logic       ex_ack;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       halt_req;
  logic       done;
  logic [1:0] cnt_set;
  logic       stop;
  logic [7:0] ir;
  logic [7:0] pc;

  int n_checks = 0;
  int n_err = 0;

  fetch_exec_sequencer #(
    .AW(8), .DW(8), .RESET_PC(8'h10), .HALT_OP(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .T1_Mif(T1_Mif), .T2_Mif(T2_Mif),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ex_req(ex_req), .ex_beat(ex_beat), .ex_ack(ex_ack),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .halt_req(halt_req), .done(done),
    .cnt_set(cnt_set), .stop(stop), .ir(ir), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: outstanding transaction flags and architectural regs
  bit         m_fetch, m_exec, m_done, m_halt;
  bit         m_was_done, m_fin, m_stop_now;
  logic [1:0] m_bidx;
  logic [7:0] m_pc, m_ir, m_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fetch = 0; m_exec = 0; m_done = 0; m_halt = 0;
      m_bidx = 0; m_pc = 8'h10; m_ir = 8'h00; m_addr = 8'h10;
    end else begin
      m_stop_now = (m_ir == 8'hFF) | m_halt;
      m_was_done = m_done;
      m_done = 0;
      m_fin = 0;
      if (m_fetch) begin
        if (mem_ack) begin
          m_ir = mem_rdata; m_fetch = 0; m_done = 1; m_fin = 1;
        end
      end else if (m_exec) begin
        if (ex_ack) begin
          m_exec = 0; m_done = 1;
        end
      end else if (!m_was_done) begin
        if (T1_Mif) begin
          m_fetch = 1; m_addr = m_pc;
        end else if (T1) begin
          m_exec = 1; m_bidx = 0;
        end else if (T2) begin
          m_exec = 1; m_bidx = 1;
        end else if (T3) begin
          m_exec = 1; m_bidx = 2;
        end else if (T4) begin
          m_exec = 1; m_bidx = 3;
        end
      end
      if (pc_load) m_pc = pc_load_val;
      else if (m_fin) m_pc = m_pc + 8'd1;
      m_halt = halt_req | (m_halt & ~(T2_Mif & m_stop_now));
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("cyc_mem_rd_req", mem_rd_req, m_fetch);
    chk("cyc_ex_req", ex_req, m_exec);
    chk("cyc_ex_beat", ex_beat, m_bidx);
    chk("cyc_done", done, m_done);
    chk("cyc_ir", ir, m_ir);
    chk("cyc_pc", pc, m_pc);
    chk("cyc_mem_addr", mem_addr, m_fetch ? m_addr : m_pc);
    chk("cyc_cnt_set", cnt_set, m_ir[7:6]);
    chk("cyc_stop", stop, (m_ir == 8'hFF) | m_halt);
  end

  initial begin
    rst_n = 0;
    T1_Mif = 0; T2_Mif = 0; T1 = 0; T2 = 0; T3 = 0; T4 = 0;
    mem_rdata = 0; mem_ack = 0; ex_ack = 0;
    pc_load = 0; pc_load_val = 0; halt_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 8'h10);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_ir", ir, 0);
    chk("rst_done", done, 0);
    rst_n = 1;

    // Fetch with wait states
    @(negedge clk) T1_Mif = 1;
    @(negedge clk) T1_Mif = 0;
    chk("f1_req", mem_rd_req, 1);
    chk("f1_addr", mem_addr, 8'h10);
    repeat (2) @(negedge clk);
    mem_ack = 1; mem_rdata = 8'h8C;
    @(negedge clk) mem_ack = 0;
    chk("f1_done", done, 1);
    chk("f1_ir", ir, 8'h8C);
    chk("f1_pc", pc, 8'h11);
    chk("f1_cnt_set", cnt_set, 2);
    @(negedge clk);
    chk("f1_done_once", done, 0);

    // Zero-wait fetch with pc wrap, fetching HALT_OP
    pc_load = 1; pc_load_val = 8'hFF;
    @(negedge clk) pc_load = 0; T1_Mif = 1;
    @(negedge clk) T1_Mif = 0; mem_ack = 1; mem_rdata = 8'hFF;
    chk("f2_addr", mem_addr, 8'hFF);
    @(negedge clk) mem_ack = 0;
    chk("f2_done", done, 1);
    chk("f2_pc_wrap", pc, 8'h00);
    chk("f2_ir", ir, 8'hFF);
    @(negedge clk) T2_Mif = 1;
    chk("f2_stop_decode", stop, 1);
    @(negedge clk) T2_Mif = 0;

    // Execute beats T1..T3, each acked after one clock
    for (int n = 0; n < 3; n++) begin
      T1 = (n == 0); T2 = (n == 1); T3 = (n == 2);
      @(negedge clk) T1 = 0; T2 = 0; T3 = 0;
      chk("ex_req_on", ex_req, 1);
      chk("ex_beat_idx", ex_beat, n);
      @(negedge clk) ex_ack = 1;
      chk("ex_no_early_done", done, 0);
      @(negedge clk) ex_ack = 0;
      chk("ex_done", done, 1);
      @(negedge clk);
    end

    // Stray acks with nothing outstanding
    ex_ack = 1; mem_ack = 1;
    @(negedge clk) ex_ack = 0; mem_ack = 0;
    @(negedge clk);
    chk("stray_no_done", done, 0);

    // External halt request against a non-halt instruction
    @(negedge clk) T1_Mif = 1;
    @(negedge clk) T1_Mif = 0; mem_ack = 1; mem_rdata = 8'h00;
    @(negedge clk) mem_ack = 0;
    @(negedge clk);
    chk("h_ir_zero", ir, 0);
    chk("h_stop_clear", stop, 0);
    halt_req = 1;
    @(negedge clk) halt_req = 0;
    chk("h_stop_set", stop, 1);
    @(negedge clk) T2_Mif = 1;
    chk("h_stop_decode", stop, 1);
    @(negedge clk) T2_Mif = 0;
    chk("h_stop_cleared", stop, 0);

    // Jump coincident with fetch ack
    pc_load = 1; pc_load_val = 8'h20;
    @(negedge clk) pc_load = 0; T1_Mif = 1;
    @(negedge clk) T1_Mif = 0;
    chk("j_addr", mem_addr, 8'h20);
    @(negedge clk);
    mem_ack = 1; mem_rdata = 8'h41; pc_load = 1; pc_load_val = 8'h40;
    @(negedge clk) mem_ack = 0; pc_load = 0;
    chk("j_pc", pc, 8'h40);
    chk("j_ir", ir, 8'h41);
    chk("j_done", done, 1);
    @(negedge clk);
    chk("j_done_once", done, 0);

    // Reset in the middle of a fetch, then a late ack
    @(negedge clk) T1_Mif = 1;
    @(negedge clk) T1_Mif = 0;
    chk("r_req_before", mem_rd_req, 1);
    #2 rst_n = 0;
    #1;
    chk("r_req_dropped", mem_rd_req, 0);
    chk("r_ir", ir, 0);
    chk("r_pc", pc, 8'h10);
    @(negedge clk) rst_n = 1;
    @(negedge clk) mem_ack = 1; mem_rdata = 8'h55;
    @(negedge clk) mem_ack = 0;
    chk("r_late_no_done", done, 0);
    @(negedge clk);
    chk("r_late_ir", ir, 0);

    // T4 during an outstanding T2 beat is ignored
    @(negedge clk) T2 = 1;
    @(negedge clk) T2 = 0; T4 = 1;
    chk("x_beat", ex_beat, 1);
    @(negedge clk) T4 = 0;
    chk("x_beat_held", ex_beat, 1);
    ex_ack = 1;
    @(negedge clk) ex_ack = 0;
    chk("x_done", done, 1);
    @(negedge clk);

    // Coincident T1_Mif and T1: fetch wins
    T1_Mif = 1; T1 = 1;
    @(negedge clk) T1_Mif = 0; T1 = 0;
    chk("c_fetch_wins", mem_rd_req, 1);
    chk("c_no_exec", ex_req, 0);
    mem_ack = 1; mem_rdata = 8'h00;
    @(negedge clk) mem_ack = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
